// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
package fifo_reader_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // One extra bit keeps BURST_LEN=1 at a legal nonzero width.
  function automatic int burst_cnt_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer; head entry is the registered stream word.
//   state | meaning
//   EMPTY | no word held, head is stale
//   ONE   | head holds the next word to deliver
//   TWO   | head and tail both hold words, tail is younger
module fifo_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output buf_state_t            state,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= din;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= din;
              state <= TWO;
            end
            2'b01: state <= EMPTY;
            2'b11: head  <= din;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            head <= tail;
            if (push) tail  <= din;
            else      state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // The read credit logic must never land a word on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(state == TWO && push && !pop));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO onto a valid/ready burst stream.
// Optional FIFO_READER_STATS_EN adds the rd_count popped-word counter.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  localparam int CNT_W = burst_cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic             inflight;
  logic             pop;
  logic [1:0]       occupancy;
  logic [2:0]       credit;
  logic [CNT_W-1:0] burst_cnt;
  buf_state_t       buf_state;

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .pop      (pop),
    .din      (fifo_rdata),
    .head     (m_data),
    .state    (buf_state),
    .occupancy(occupancy)
  );

  assign m_valid = (buf_state != EMPTY);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (burst_cnt == LAST_IDX);

  // Words already held or on their way, minus the one leaving this edge.
  assign credit     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !reset & !fifo_empty & (credit < 3'(SKID_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (pop) begin
      if (m_last) burst_cnt <= '0;
      else        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rd_count <= 16'd0;
    else if (pop) rd_count <= rd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]   rd_count;
`endif

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: the bench writes, the reader drains.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % 256];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor samples 1 time unit before each rising edge.
  logic [8:0] got[$];
  int         stamp[$];
  int         cyc  = 0;
  int         n_rd = 0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (!reset) begin
      if (fifo_rd_en) n_rd++;
      if (m_valid && m_ready) begin
        got.push_back({m_last, m_data});
        stamp.push_back(cyc);
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic start_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    got.delete();
    stamp.delete();
    n_rd = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, got.size(), n);
  endtask

  // Expect n sequential words starting at 'first', beginning a fresh burst.
  task automatic check_burst(input string tag, input logic [DW-1:0] first, input int n);
    logic [8:0] e;
    for (int i = 0; i < n && i < got.size(); i++) begin
      e = {((i % BL) == BL - 1), DW'(first + i)};
      check_val(tag, got[i], e);
    end
  endtask

  initial begin
    reset   = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // T1: reset values and first-word latency
    push_word(8'h11);
    push_word(8'h22);
    m_ready = 1'b1;
    #1;
    check_val("rst_valid", m_valid, 0);
    check_val("rst_data", m_data, 0);
    check_val("rst_last", m_last, 0);
    check_val("rst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_READER_STATS_EN
    check_val("rst_rd_count", rd_count, 0);
`endif
    release_reset();
    #1;
    check_val("t1_rd_en_c0", fifo_rd_en, 1);
    @(negedge clk); #1;
    check_val("t1_valid_c1", m_valid, 0);
    @(negedge clk); #1;
    check_val("t1_valid_c2", m_valid, 1);
    check_val("t1_data_c2", m_data, 8'h11);
    @(negedge clk); #1;
    check_val("t1_valid_c3", m_valid, 1);
    check_val("t1_data_c3", m_data, 8'h22);
    @(negedge clk); #1;
    check_val("t1_valid_c4", m_valid, 0);

    // T2: 8 words back to back, last on 4th and 8th
    start_reset();
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    m_ready = 1'b1;
    release_reset();
    wait_words(8, 30, "t2_count");
    check_burst("t2_word", 8'h01, 8);
    for (int i = 1; i < 8 && i < stamp.size(); i++)
      check_val("t2_no_bubble", stamp[i] - stamp[0], i);
`ifdef FIFO_READER_STATS_EN
    check_val("t2_rd_count", rd_count, 8);
`endif

    // T3: backpressure pulls at most two words ahead
    start_reset();
    for (int i = 1; i <= 6; i++) push_word(DW'(i));
    m_ready = 1'b0;
    release_reset();
    repeat (10) @(negedge clk);
    #1;
    check_val("t3_rd_pulses", n_rd, 2);
    check_val("t3_valid_held", m_valid, 1);
    check_val("t3_data_held", m_data, 8'h01);
    check_val("t3_last_held", m_last, 0);
    m_ready = 1'b1;
    wait_words(6, 30, "t3_count");
    check_burst("t3_word", 8'h01, 6);
    check_val("t3_rd_total", n_rd, 6);

    // T4: m_ready toggling every cycle
    start_reset();
    for (int i = 0; i < 12; i++) push_word(DW'(8'h41 + i));
    m_ready = 1'b1;
    release_reset();
    begin
      int k = 0;
      while (got.size() < 12 && k < 60) begin
        @(negedge clk);
        m_ready = !m_ready;
        k++;
      end
    end
    m_ready = 1'b1;
    check_val("t4_count", got.size(), 12);
    check_burst("t4_word", 8'h41, 12);

    // T5: FIFO runs dry mid-burst, burst position retained
    start_reset();
    push_word(8'h11);
    push_word(8'h22);
    m_ready = 1'b1;
    release_reset();
    wait_words(2, 10, "t5_count_a");
    repeat (5) @(negedge clk);
    #1;
    check_val("t5_idle_valid", m_valid, 0);
    push_word(8'h33);
    push_word(8'h44);
    wait_words(4, 15, "t5_count_b");
    if (got.size() >= 4) begin
      check_val("t5_word3", got[2], {1'b0, 8'h33});
      check_val("t5_word4", got[3], {1'b1, 8'h44});
    end

    // T6: reset with a word buffered and another in flight
    start_reset();
    for (int i = 0; i < 6; i++) push_word(DW'(8'h51 + i));
    m_ready = 1'b0;
    release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", m_valid, 0);
    check_val("t6_rst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_READER_STATS_EN
    check_val("t6_rd_count", rd_count, 0);
`endif
    got.delete();
    stamp.delete();
    n_rd = 0;
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    reset = 1'b0;
    wait_words(4, 20, "t6_count");
    check_burst("t6_word", 8'h53, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
